// File: rtl/instr_encoder.sv
// Instruction issue buffer: packs instruction fields into 28-bit words, queues them
// in a DEPTH-entry FIFO and issues one word per cycle on d with a one-cycle en strobe.
module instr_encoder #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    func,
    input  logic [9:0]    rs1,
    input  logic [9:0]    rs2,
    input  logic [3:0]    opcode,
    input  logic          flush,
    input  logic          out_ready,
    output logic [27:0]   d,
    output logic          en,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);

    logic [27:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Flags and handshake decisions all come from the registered count, so a word
    // written into an empty FIFO can only be popped on the following edge.
    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign in_ready = reset && !full;
    assign push     = in_valid && in_ready && !flush;
    assign pop      = !empty && out_ready && !flush;

    // NOTE: the storage array has no reset; a slot is only read after it was written,
    // and leaving it unreset lets it map onto plain register-file/RAM cells.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {func, rs1, rs2, opcode};
        end
    end

    // NOTE: all state below uses non-blocking assignments so every update reads the
    // pre-edge values of count and the pointers, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            d      <= '0;
            en     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                d      <= mem[rd_ptr];
                en     <= 1'b1;
                rd_ptr <= rd_ptr + 1'b1;
            end else begin
                en     <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Issue-side counterpart of the instruction decoder: packs instruction fields into a 28-bit instruction word, buffers the words in a DEPTH-entry FIFO, and emits them one per cycle as a word `d` with a one-cycle `en` strobe. `d` and `en` connect directly to the decoder's `d` and `en` inputs. A downstream `out_ready` provides backpressure, and a `flush` discards all queued instructions, for example on a program restart.

## Interface
- DEPTH, 8: FIFO entries; power of two, at least 2. AW = log2(DEPTH).
- clk  in  1  clock, rising-edge.
- reset  in  1  synchronous, active-low.
- in_valid  in  1  upstream field set valid.
- in_ready  out  1  FIFO can accept; equals !full, forced 0 while reset is low.
- func  in  4  function field.
- rs1  in  10  source/address field 1.
- rs2  in  10  source/address field 2.
- opcode  in  4  opcode field.
- flush  in  1  discard all queued words and the pending output strobe.
- out_ready  in  1  downstream can take a word this cycle.
- d  out  28  packed instruction word, registered.
- en  out  1  one-cycle strobe: `d` holds a newly issued word.
- count  out  AW+1  occupancy, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

## Operation
- Packing: word = {func, rs1, rs2, opcode}.
  - func occupies [27:24], rs1 [23:14], rs2 [13:4], opcode [3:0].
  - Fields are taken verbatim, with no validation.
- Push: when in_valid && in_ready, the packed word is written at the write pointer; the write pointer increments.
- Pop: when !empty && out_ready, the head word is loaded into `d`, `en` <= 1, and the read pointer increments.
  - Otherwise `en` <= 0 and `d` holds its previous value.
- Pointers are AW bits wide and wrap modulo DEPTH. `count` is tracked separately:
  - +1 on push only.
  - −1 on pop only.
  - unchanged on push and pop in the same cycle.
- Flags and decisions:
  - `empty` and `full` are derived combinationally from the registered `count`.
  - Push and pop decisions use the pre-edge `count`.
  - Pushing into an empty FIFO cannot pop that word in the same cycle.
  - When full, pushes are refused even if a pop happens in the same cycle.
- Simultaneous push and pop at 0 < count < DEPTH: both complete and `count` is unchanged.
- Flush (priority below reset, above everything else):
  - Pointers and `count` go to 0, `en` <= 0, `d` <= 0.
  - A push accepted in the same cycle is dropped.
  - No pop occurs in a flush cycle.
- Reset (reset low at a clock edge):
  - d=0, en=0, count=0, empty=1, full=0.
  - Pointers are set to 0.
  - in_ready=0 for the whole time reset is low.
- Reset mid-stream: all queued words are lost. No strobe appears in the cycle after the reset edge.
- FIFO storage contents are not reset and are never observable before they are written.

## Timing
- Push at edge N: `count` and `empty` update after N.
  - The earliest pop is at edge N+1, given out_ready.
  - `en` is high in cycle N+1..N+2, and the decoder captures the word at edge N+2.
- Minimum input-to-strobe latency: 1 cycle.
- Throughput: 1 word/cycle sustained, with push and pop in the same cycle.
- `en` is asserted for exactly one cycle per issued word. Consecutive pops give back-to-back `en` high, with `d` changing every cycle.
- Backpressure (out_ready=0): no pop, `en` goes low at the next edge, and `d` holds.
- in_ready is combinational from registered state only. It has no path from in_valid or out_ready.

## Test plan
- Packing and latency:
  - After reset, push func=4'h3, rs1=10'h2A5, rs2=10'h0F1, opcode=4'h9, with out_ready=1.
  - Required: one cycle later en=1 with d=28'h3A94F19; en=0 in the following cycle; count returns to 0.
- Fill and backpressure:
  - With out_ready=0, push 9 words with opcode=0..8.
  - Required: the first 8 are accepted, full=1 and in_ready=0 after the 8th, the 9th is not accepted, count=8.
  - Then set out_ready=1: en is high for 8 consecutive cycles with opcodes 0..7 in order, then empty=1.
- Wrap-around and concurrency:
  - Hold out_ready=1 and push 20 words back-to-back.
  - Required: count never exceeds 1, en is high every cycle from the 2nd cycle on, order is preserved across pointer wrap, and no word is lost or duplicated.
- Full plus pop:
  - At count=8, assert in_valid and out_ready together.
  - Required: the pop occurs, the push is refused, and count=7.
  - Next cycle: the push is accepted and count stays 7.
- Flush:
  - At count=5, assert flush together with in_valid.
  - Required: next cycle count=0, empty=1, en=0, d=0; the pushed word never appears on `d`.
- Reset mid-operation:
  - Pull reset low for 1 cycle at count=4 while en=1.
  - Required: next cycle d=0, en=0, count=0, in_ready=0 during reset, in_ready=1 after release.
